opl3_reg_wr_arbiter: RTL and testbench
======================================

// Module: opl3_reg_wr_arbiter
// PURPOSE
//  Shares the single opl3_reg_wr register-write bus between two requesters: A (host bus) and B (sequencer/player).
//  Each requester has its own FIFO. A round-robin scheduler drains the FIFOs into one registered opl3_reg_wr stream.
//  Issued writes are paced by a programmable minimum gap. Output feeds the operator/channel register memories and global regs (0x08, 0xBD, 0x104/0x105).
// PARAMETERS
//  FIFO_DEPTH     4   entries per requester FIFO; power of two, >=2
//  WR_GAP_CYCLES  2   idle clk cycles forced after each issued write; 0 = back-to-back allowed
//  GAP_W          4   width of gap counter; must hold WR_GAP_CYCLES
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-low reset
//  a_valid       in   1   requester A has a write
//  a_ready       out  1   A FIFO can accept (= !a_full)
//  a_wr          in   17  A write {bank[16], addr[15:8], data[7:0]}
//  b_valid       in   1   requester B has a write
//  b_ready       out  1   B FIFO can accept (= !b_full)
//  b_wr          in   17  B write, same packing as a_wr
//  flush         in   1   sync clear of both FIFOs
//  opl3_reg_wr   out  18  {valid[17], bank[16], addr[15:8], data[7:0]}; registered
//  a_level       out  $clog2(FIFO_DEPTH)+1  A FIFO occupancy
//  b_level       out  $clog2(FIFO_DEPTH)+1  B FIFO occupancy
//  busy          out  1   any FIFO non-empty, or state != IDLE
// BEHAVIOUR
//  Reset (reset==0, async): FIFOs empty; opl3_reg_wr=0; levels=0; busy=0; state=IDLE; gap_cnt=0; last_grant=B.
//   - a_ready/b_ready=1 after reset release.
//  Push: x_valid && x_ready at a clk edge stores x_wr at the tail.
//   - x_ready depends only on the full flag, never on same-cycle pop; a full FIFO stays not-ready in a cycle it pops.
//   - Simultaneous push+pop on one non-full FIFO: level unchanged, order preserved.
//  FSM states: IDLE, GAP.
//   IDLE, edge with any FIFO non-empty and flush==0:
//    - grant = the only non-empty FIFO; if both non-empty, grant = !last_grant (A wins the first tie after reset).
//    - opl3_reg_wr <= {1'b1, head}; pop granted FIFO; last_grant <= grant.
//    - WR_GAP_CYCLES>0: gap_cnt <= WR_GAP_CYCLES, go GAP. WR_GAP_CYCLES==0: stay IDLE.
//   IDLE, edge with nothing to issue: opl3_reg_wr[17] <= 0 (payload bits may hold).
//   GAP: opl3_reg_wr[17] <= 0; gap_cnt decrements; at gap_cnt==1 go IDLE.
//  Valid pulse: opl3_reg_wr[17] is high for exactly one cycle per write.
//   - Consecutive valids are separated by exactly WR_GAP_CYCLES low cycles while work is pending.
//  Latency: write pushed into an empty FIFO at edge k, arbiter IDLE -> opl3_reg_wr[17]=1 in cycle after edge k+1.
//  No bypass: a push and an issue of the same entry never occur on the same edge.
//  flush==1 at an edge:
//   - both FIFOs empty, no issue on that edge, pushes on that edge are discarded.
//   - GAP countdown continues; last_grant kept.
//  Order: per-requester FIFO order always preserved; no entry lost or duplicated except via flush.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  Full/empty derive from level; level saturates 0..FIFO_DEPTH by construction.
//  Async reset mid-write or mid-GAP: all state cleared immediately; opl3_reg_wr[17] drops in the same cycle.
// TESTING
//  1. Reset, WR_GAP=2; A pushes {0,0xA0,0x41} at edge 5:
//     - opl3_reg_wr=0x0A041|valid in cycle after edge 6 only; a_level 1->0.
//  2. A and B both hold 3 entries:
//     - issue order A0,B0,A1,B1,A2,B2; valid pulses spaced exactly 2 low cycles.
//  3. WR_GAP_CYCLES=0, A holds 4 entries: 4 consecutive valid cycles, data in FIFO order.
//  4. Fill A to 4 (a_ready=0), keep a_valid high:
//     - no push while full; a_ready returns 1 the cycle after the first pop; 5th entry is accepted afterwards.
//  5. flush with A=3, B=2 mid-GAP:
//     - levels->0; no further valids; gap still expires; next push issues normally.
//  6. Assert reset low during the valid cycle of a B write:
//     - opl3_reg_wr=0 immediately; levels=0; after release, the first A/B tie grants A.

Source files
------------

// File: rtl/opl3_reg_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// opl3_reg_wr_arbiter_if
// Bundles the request, control and output signals of the OPL3 register-write
// arbiter.
//   master modport : requester side (drives a_*/b_* requests and flush)
//   slave  modport : arbiter side (drives ready flags, levels, busy, the
//                    registered opl3_reg_wr stream)
// Signals:
//   a_valid/a_ready/a_wr   requester A handshake, a_wr = {bank, addr[7:0], data[7:0]}
//   b_valid/b_ready/b_wr   requester B handshake, same packing
//   flush                  synchronous clear of both FIFOs
//   opl3_reg_wr            {valid, bank, addr[7:0], data[7:0]}
//   a_level/b_level        FIFO occupancy
//   busy                   any FIFO non-empty or arbiter not idle
// ----------------------------------------------------------------------------
interface opl3_reg_wr_arbiter_if #(
    parameter int unsigned FIFO_DEPTH = 4
) ();
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             a_valid;
    logic             a_ready;
    logic [16:0]      a_wr;
    logic             b_valid;
    logic             b_ready;
    logic [16:0]      b_wr;
    logic             flush;
    logic [17:0]      opl3_reg_wr;
    logic [LVL_W-1:0] a_level;
    logic [LVL_W-1:0] b_level;
    logic             busy;

    modport master (
        output a_valid, a_wr, b_valid, b_wr, flush,
        input  a_ready, b_ready, opl3_reg_wr, a_level, b_level, busy
    );

    modport slave (
        input  a_valid, a_wr, b_valid, b_wr, flush,
        output a_ready, b_ready, opl3_reg_wr, a_level, b_level, busy
    );
endinterface

// File: rtl/opl3_reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// opl3_reg_wr_arbiter
// Shares the single OPL3 register-write bus between requester A (host bus) and
// requester B (sequencer/player). Each requester owns a FIFO; a round-robin
// scheduler drains both into one registered opl3_reg_wr stream, forcing
// WR_GAP_CYCLES idle cycles after every issued write.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   slave side of opl3_reg_wr_arbiter_if (requests, flush, output
//            stream, levels, busy)
// ----------------------------------------------------------------------------
module opl3_reg_wr_arbiter #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned WR_GAP_CYCLES = 2,
    parameter int unsigned GAP_W         = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    opl3_reg_wr_arbiter_if.slave  io_bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {
        StIdle,
        StGap
    } state_t;

    // Arbiter state
    state_t           r_state;
    state_t           w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             r_last_grant;  // 1 = B was granted last
    logic             w_last_nxt;
    logic [17:0]      r_wr;
    logic [17:0]      w_wr_nxt;

    // Per-requester FIFOs, index 0 = A, 1 = B
    logic [16:0]      r_mem    [2][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [LVL_W-1:0] r_level  [2];

    logic [1:0]       w_in_valid;
    logic [16:0]      w_in_wr  [2];
    logic [16:0]      w_head   [2];
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic             w_grant_b;

    assign w_in_valid = {io_bus.b_valid, io_bus.a_valid};
    assign w_in_wr[0] = io_bus.a_wr;
    assign w_in_wr[1] = io_bus.b_wr;

    for (genvar g = 0; g < 2; g++) begin : g_req
        assign w_full[g]  = (r_level[g] == LVL_W'(FIFO_DEPTH));
        assign w_empty[g] = (r_level[g] == '0);
        // Ready depends only on full, so a flush-cycle push is simply dropped
        assign w_push[g]  = w_in_valid[g] & ~w_full[g] & ~io_bus.flush;
        assign w_head[g]  = r_mem[g][r_rd_ptr[g]];
    end

    // FIFO storage carries no reset; only pointers/levels define validity
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < 2; r++) begin
            if (w_push[r]) begin
                r_mem[r][r_wr_ptr[r]] <= w_in_wr[r];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 2; r++) begin
                r_wr_ptr[r] <= '0;
                r_rd_ptr[r] <= '0;
                r_level[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (io_bus.flush) begin
                    r_wr_ptr[r] <= '0;
                    r_rd_ptr[r] <= '0;
                    r_level[r]  <= '0;
                end else begin
                    if (w_push[r]) begin
                        r_wr_ptr[r] <= r_wr_ptr[r] + PTR_W'(1);
                    end
                    if (w_pop[r]) begin
                        r_rd_ptr[r] <= r_rd_ptr[r] + PTR_W'(1);
                    end
                    r_level[r] <= r_level[r] + LVL_W'(w_push[r]) - LVL_W'(w_pop[r]);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_gap_cnt    <= '0;
            r_last_grant <= 1'b1;
            r_wr         <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_last_grant <= w_last_nxt;
            r_wr         <= w_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_last_nxt  = r_last_grant;
        w_wr_nxt    = {1'b0, r_wr[16:0]};
        w_pop       = 2'b00;
        w_grant_b   = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Pop uses the pre-edge empty flag, so a fresh push is never
                // issued on the edge it is written.
                if (!io_bus.flush && (w_empty != 2'b11)) begin
                    if (w_empty == 2'b00) begin
                        w_grant_b = ~r_last_grant;
                    end else begin
                        w_grant_b = w_empty[0];
                    end
                    w_pop      = w_grant_b ? 2'b10 : 2'b01;
                    w_wr_nxt   = {1'b1, (w_grant_b ? w_head[1] : w_head[0])};
                    w_last_nxt = w_grant_b;
                    if (WR_GAP_CYCLES != 0) begin
                        w_state_nxt = StGap;
                        w_gap_nxt   = GAP_W'(WR_GAP_CYCLES);
                    end
                end
            end
            StGap: begin
                // Countdown is independent of flush
                w_gap_nxt = r_gap_cnt - GAP_W'(1);
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign io_bus.a_ready     = ~w_full[0];
    assign io_bus.b_ready     = ~w_full[1];
    assign io_bus.a_level     = r_level[0];
    assign io_bus.b_level     = r_level[1];
    assign io_bus.opl3_reg_wr = r_wr;
    assign io_bus.busy        = (w_empty != 2'b11) | (r_state != StIdle);

endmodule

// File: tb/tb_opl3_reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_opl3_reg_wr_arbiter
// Two arbiter instances share one stimulus stream: lane 0 with a gap of 2,
// lane 1 with back-to-back issue. Each lane keeps a queue-based reference
// model that predicts issued writes (data and edge index) into a scoreboard;
// a negedge monitor pops and compares whenever the DUT shows a valid write,
// and also checks levels, ready flags and busy every cycle.
// ----------------------------------------------------------------------------
module tb_opl3_reg_wr_arbiter;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_valid = 1'b0;
    logic [16:0] a_wr = '0;
    logic        b_valid = 1'b0;
    logic [16:0] b_wr = '0;
    logic        flush = 1'b0;
    logic [17:0] obs_wr [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane, input longint act,
                       input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s lane%0d: got %0h, expected %0h at %0t",
                     name, lane, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int GAP = (g == 0) ? 2 : 0;

        opl3_reg_wr_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

        assign bus.a_valid = a_valid;
        assign bus.a_wr    = a_wr;
        assign bus.b_valid = b_valid;
        assign bus.b_wr    = b_wr;
        assign bus.flush   = flush;
        assign obs_wr[g]   = bus.opl3_reg_wr;

        opl3_reg_wr_arbiter #(
            .FIFO_DEPTH   (DEPTH),
            .WR_GAP_CYCLES(GAP),
            .GAP_W        (4)
        ) u_dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .io_bus (bus)
        );

        // Reference model: queues per requester, issue allowed when more
        // than GAP edges have passed since the last issue.
        logic [16:0] qa[$];
        logic [16:0] qb[$];
        logic [16:0] exp_d[$];
        int          exp_n[$];
        int          n = 0;
        int          last_issue = -100;
        bit          last_b = 1'b1;
        int          sa;
        int          sb;
        bit          pick_b;
        logic [16:0] d;

        initial forever begin
            @(posedge clk);
            n++;
            if (!rst_n) begin
                qa.delete();
                qb.delete();
                exp_d.delete();
                exp_n.delete();
                last_issue = -100;
                last_b = 1'b1;
            end else if (flush) begin
                qa.delete();
                qb.delete();
            end else begin
                sa = qa.size();
                sb = qb.size();
                if ((n - last_issue > GAP) && (sa > 0 || sb > 0)) begin
                    pick_b = (sa > 0 && sb > 0) ? !last_b : (sa == 0);
                    d = pick_b ? qb.pop_front() : qa.pop_front();
                    exp_d.push_back(d);
                    exp_n.push_back(n);
                    last_issue = n;
                    last_b = pick_b;
                end
                if (a_valid && sa < int'(DEPTH)) qa.push_back(a_wr);
                if (b_valid && sb < int'(DEPTH)) qb.push_back(b_wr);
            end
        end

        // Monitor
        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_d.delete();
                exp_n.delete();
                chk("rst_wr", g, longint'(bus.opl3_reg_wr), 0);
                chk("rst_busy", g, longint'(bus.busy), 0);
            end else begin
                chk("a_level", g, longint'(bus.a_level), longint'(qa.size()));
                chk("b_level", g, longint'(bus.b_level), longint'(qb.size()));
                chk("a_ready", g, longint'(bus.a_ready), longint'(qa.size() < int'(DEPTH)));
                chk("b_ready", g, longint'(bus.b_ready), longint'(qb.size() < int'(DEPTH)));
                chk("busy", g, longint'(bus.busy),
                    longint'(qa.size() > 0 || qb.size() > 0 || (n - last_issue < GAP)));
                if (bus.opl3_reg_wr[17]) begin
                    if (exp_d.size() == 0) begin
                        chk("unexpected_valid", g, longint'(bus.opl3_reg_wr[17]), 0);
                    end else begin
                        chk("wr_data", g, longint'(bus.opl3_reg_wr[16:0]),
                            longint'(exp_d.pop_front()));
                        chk("wr_edge", g, longint'(n), longint'(exp_n.pop_front()));
                    end
                end else if (exp_n.size() > 0 && exp_n[0] <= n) begin
                    chk("missing_valid", g, longint'(bus.opl3_reg_wr[17]), 1);
                    void'(exp_d.pop_front());
                    void'(exp_n.pop_front());
                end
            end
        end

        // Reset must clear outputs immediately, not at the next edge
        initial forever begin
            @(negedge rst_n);
            #1;
            chk("async_rst_wr", g, longint'(bus.opl3_reg_wr), 0);
            chk("async_rst_a_level", g, longint'(bus.a_level), 0);
            chk("async_rst_b_level", g, longint'(bus.b_level), 0);
        end
    end

    task automatic cyc(input bit av, input logic [16:0] ad, input bit bv,
                       input logic [16:0] bd, input bit fl);
        @(negedge clk);
        a_valid = av;
        a_wr    = ad;
        b_valid = bv;
        b_wr    = bd;
        flush   = fl;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [16:0] ra;
        logic [16:0] rb;
        bit          hit;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Single A write into empty arbiter
        idle(3);
        cyc(1'b1, 17'h0A041, 1'b0, '0, 1'b0);
        idle(6);

        // Both requesters loaded: alternating grants
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 17'h00100 + 17'(i), 1'b1, 17'h10200 + 17'(i), 1'b0);
        end
        idle(25);

        // Sustained A stream (back-to-back on lane 1)
        for (int i = 0; i < 6; i++) cyc(1'b1, 17'h02000 + 17'(i), 1'b0, '0, 1'b0);
        idle(25);

        // Hold a_valid high past full
        for (int i = 0; i < 12; i++) cyc(1'b1, 17'h03000 + 17'(i), 1'b0, '0, 1'b0);
        idle(40);

        // Flush while loaded and mid-gap, then a normal write
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 17'h04000 + 17'(i), (i < 2), 17'h14000 + 17'(i), 1'b0);
        end
        cyc(1'b1, 17'h04F00, 1'b1, 17'h14F00, 1'b1);
        idle(5);
        cyc(1'b1, 17'h05555, 1'b0, '0, 1'b0);
        idle(10);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            ra = 17'($urandom);
            rb = 17'($urandom);
            cyc(bit'($urandom_range(0, 1)), ra, bit'($urandom_range(0, 1)), rb,
                ($urandom_range(0, 31) == 0));
        end
        idle(40);

        // Reset during the valid cycle of a B write
        cyc(1'b0, '0, 1'b1, 17'h1BD20, 1'b0);
        idle(1);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (obs_wr[0][17] && obs_wr[0][16:0] == 17'h1BD20) hit = 1'b1;
        end
        chk("b_valid_seen", 0, longint'(hit), 1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // First tie after reset must grant A
        idle(2);
        cyc(1'b1, 17'h0AAAA, 1'b1, 17'h1BBBB, 1'b0);
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
